rr_mux_arbiter_4: RTL and testbench
===================================

RR_MUX_ARBITER_4 -- requirements
Module: rr_mux_arbiter_4

Interface
REQ-001 Parameter: W, default 4, data width per requester (W >= 1).
REQ-002 Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  4  per-requester valid.
- in_data  input  4 x W  requester data, packed; requester i occupies bits [i*W +: W].
- in_last  input  4  per-requester last-beat flag; used only when the lock feature is compiled in.
- in_ready  output  4  per-requester accept.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered selected data.
- out_sel  output  2  index of the requester that supplied out_data.
- out_ready  input  1  downstream accept.
REQ-003 The block SHALL use one clock (clk) and an asynchronous active-high reset (rst).

Function
REQ-004 The block SHALL share one 4:1 W-bit mux among 4 requesters using round-robin arbitration.
REQ-005 Output slot: a one-entry output register (out_valid, out_data, out_sel); the slot is free when out_valid==0 or out_ready==1.
REQ-006 Arbitration: when the slot is free, grant the first requester with in_valid=1, searching from ptr, ptr+1, ... mod 4.
REQ-007 Ready rule: in_ready[g]=1 only for the granted index g, and only when the slot is free; all other in_ready bits are 0; at most one bit is set; in_ready is combinational from in_valid, ptr, out_valid and out_ready.
REQ-008 Transfer: a beat transfers on a clk edge where in_valid[g] & in_ready[g]; out_data <= in_data[g], out_sel <= g, out_valid <= 1; latency is 1 cycle.
REQ-009 After a transfer from g, ptr <= (g+1) mod 4; wrap 3 -> 0.
REQ-010 A requester that does not transfer leaves ptr unchanged.
REQ-011 Drain: on out_ready=1 with no transfer, out_valid <= 0.
REQ-012 Simultaneous drain and transfer: the new beat replaces the old one in the same cycle; this gives full throughput of 1 beat per cycle.
REQ-013 Stall: when out_valid=1 and out_ready=0, out_data and out_sel SHALL hold and all in_ready bits SHALL be 0.
REQ-014 The output SHALL NOT depend on in_data of non-granted requesters, including X values.
REQ-015 With no in_valid asserted and the slot free: no grant, and ptr holds.

Reset
REQ-016 On rst assertion, asynchronously: out_valid=0, out_data=0, out_sel=0, ptr=0, lock state cleared.
REQ-017 In_ready SHALL be all-zero while rst=1.
REQ-018 A beat in the output register is discarded on mid-operation reset.
REQ-019 The first grant after reset SHALL search from requester 0.

Configuration
REQ-020 Macro: RR_MUX_ARBITER_4_LOCK_EN.
REQ-021 With RR_MUX_ARBITER_4_LOCK_EN defined:
- A transfer with in_last[g]=0 SHALL set locked=1, lock_idx=g.
- While locked, only lock_idx may be granted, even if others are valid.
- ptr SHALL NOT advance until a transfer with in_last[lock_idx]=1; that transfer clears the lock and sets ptr=(lock_idx+1) mod 4.
REQ-022 Without the macro, in_last SHALL be ignored, there is no lock state, and the block re-arbitrates after every beat.

Structure
REQ-023 Package rr_mux_arbiter_4_pkg SHALL hold: constant N_REQ=4, and typedef req_idx_t (2-bit) used for ptr, out_sel and lock_idx.
REQ-024 Sub-module rr_pick_4 (combinational) SHALL take (valid[3:0], ptr), return (found, idx), and be instantiated once.
REQ-025 Data selection SHALL be a 4:1 W-bit mux indexed by idx.

Verification
REQ-026 Single requester: in_valid=4'b0100, in_data[2]=4'h9, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'h9, out_sel=2; ptr=3.
REQ-027 All valid, out_ready=1 continuously, data values a/b/c/d -> out_sel sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-028 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and out_data held; out_ready=1 -> the next grant completes in the same cycle.
REQ-029 Reset mid-stream: assert rst while out_valid=1 -> out_valid=0, out_sel=0 immediately; after release with in_valid=4'b1010, the first grant is 1.
REQ-030 Lock (macro on): requester 1 sends 3 beats with in_last=0,0,1 while requester 2 is valid -> out_sel=1,1,1, then 2.
REQ-031 Lock (macro off), same stimulus -> out_sel=1,2,1,2 alternating.

Source files
------------

// File: rtl/rr_mux_arbiter_4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : rr_mux_arbiter_4_pkg                                           |
// | Purpose  : Shared constants and types for the 4-way round-robin mux       |
// |            arbiter (requester count and 2-bit requester index type).      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package rr_mux_arbiter_4_pkg;

  localparam int N_REQ = 4;

  // Index of one requester; used for the search pointer, out_sel and lock_idx.
  typedef logic [1:0] req_idx_t;

endpackage
`default_nettype wire

// File: rtl/rr_mux_arbiter_4_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_pick_4                                                      |
// | Purpose  : Combinational round-robin picker. Returns the first set bit of |
// |            valid_i searching ptr_i, ptr_i+1, ... modulo 4.                |
// | Ports    : valid_i [3:0] candidate requesters                            |
// |            ptr_i         search start index                              |
// |            found_o       at least one candidate is set                   |
// |            idx_o         winning index (ptr_i when nothing is found)     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_pick_4
  import rr_mux_arbiter_4_pkg::*;
(
  input  logic [N_REQ-1:0] valid_i,
  input  req_idx_t         ptr_i,
  output logic             found_o,
  output req_idx_t         idx_o
);

  req_idx_t cand;

  // Walk the offsets from farthest to nearest so the nearest valid
  // requester (lowest offset from ptr) is the last, and therefore winning,
  // assignment.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + req_idx_t'(k);
      if (valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter_4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_mux_arbiter_4                                               |
// | Purpose  : Shares one 4:1 W-bit mux among 4 requesters with round-robin   |
// |            arbitration into a one-entry registered output slot.          |
// | Ports    : clk, rst (async, active-high)                                  |
// |            in_valid[3:0], in_data[4*W-1:0], in_last[3:0], in_ready[3:0]   |
// |            out_valid, out_data[W-1:0], out_sel[1:0], out_ready            |
// | Options  : RR_MUX_ARBITER_4_LOCK_EN - multi-beat lock: a requester that   |
// |            transfers with in_last=0 keeps the grant until its last beat.  |
// |            Undefined: in_last is ignored, re-arbitration every beat.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_mux_arbiter_4
  import rr_mux_arbiter_4_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   in_valid,
  input  logic [N_REQ*W-1:0] in_data,
  input  logic [N_REQ-1:0]   in_last,
  output logic [N_REQ-1:0]   in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output req_idx_t           out_sel,
  input  logic               out_ready
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [W-1:0]     lane [N_REQ];
  logic [N_REQ-1:0] cand_valid;
  logic             found;
  req_idx_t         idx;
  logic             slot_free;
  logic             xfer;

  req_idx_t         ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  req_idx_t         out_sel_q, out_sel_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = in_data[i*W +: W];
  end

`ifdef RR_MUX_ARBITER_4_LOCK_EN
  logic     locked_q, locked_d;
  req_idx_t lock_idx_q, lock_idx_d;

  // While locked only the lock owner is a candidate, whatever ptr says.
  assign cand_valid = locked_q ? (in_valid & (ONE_HOT0 << lock_idx_q)) : in_valid;
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign cand_valid  = in_valid;
`endif

  rr_pick_4 u_pick (
    .valid_i (cand_valid),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (idx)
  );

  // A draining slot is free in the same cycle, giving one beat per cycle.
  assign slot_free = ~out_valid_q | out_ready;
  // found implies in_valid[idx], so a grant is always a transfer.
  assign xfer      = found & slot_free & ~rst;
  assign in_ready  = xfer ? (ONE_HOT0 << idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_MUX_ARBITER_4_LOCK_EN
    locked_d    = locked_q;
    lock_idx_d  = lock_idx_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = lane[idx];
      out_sel_d   = idx;
`ifdef RR_MUX_ARBITER_4_LOCK_EN
      if (in_last[idx]) begin
        locked_d = 1'b0;
        ptr_d    = req_idx_t'(idx + 2'd1);
      end else begin
        // Mid-packet: hold ptr so fairness resumes after the last beat.
        locked_d   = 1'b1;
        lock_idx_d = idx;
      end
`else
      ptr_d = req_idx_t'(idx + 2'd1);
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_MUX_ARBITER_4_LOCK_EN
      locked_q    <= 1'b0;
      lock_idx_q  <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_MUX_ARBITER_4_LOCK_EN
      locked_q    <= locked_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter_4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rr_mux_arbiter_4                                            |
// | Purpose  : Self-checking bench for rr_mux_arbiter_4 (W=4). Table-driven  |
// |            vectors with hand-derived in_ready, a scoreboard of expected   |
// |            beats, and hand-written reset sequences.                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rr_mux_arbiter_4;

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic [3:0]  last;
    logic        rdy;
    logic [3:0]  exp;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic [1:0] sel;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sbq[$];
  logic        m_ovalid;
  logic [3:0]  m_data;
  logic [1:0]  m_sel;
  vec_t        tab1[$];
  vec_t        tab2[$];

  rr_mux_arbiter_4 #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] v, logic [15:0] d, logic [3:0] last,
                              logic rdy, logic [3:0] exp);
    vec_t t;
    t.v = v; t.d = d; t.last = last; t.rdy = rdy; t.exp = exp;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; called one time unit after a rising edge.
  task automatic apply(input vec_t t, input string tag);
    beat_t b;
    int    sel;
    in_valid  = t.v;
    in_data   = t.d;
    in_last   = t.last;
    out_ready = t.rdy;
    #1;
    check({tag, " in_ready"}, {12'd0, in_ready}, {12'd0, t.exp});
    if (t.exp != 4'd0) begin
      sel = 0;
      for (int i = 0; i < 4; i++) if (t.exp[i]) sel = i;
      b.sel  = 2'(sel);
      b.data = t.d[sel*4 +: 4];
      sbq.push_back(b);
    end
    @(posedge clk);
    #1;
    if (t.exp != 4'd0) m_ovalid = 1'b1;
    else if (t.rdy) m_ovalid = 1'b0;
    check({tag, " out_valid"}, {15'd0, out_valid}, {15'd0, m_ovalid});
    if (t.exp != 4'd0) begin
      if (sbq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL %s scoreboard: got empty queue expected a beat", tag);
      end else begin
        b = sbq.pop_front();
        check({tag, " out_data"}, {12'd0, out_data}, {12'd0, b.data});
        check({tag, " out_sel"}, {14'd0, out_sel}, {14'd0, b.sel});
        m_data = b.data;
        m_sel  = b.sel;
      end
    end else if (m_ovalid) begin
      check({tag, " hold out_data"}, {12'd0, out_data}, {12'd0, m_data});
      check({tag, " hold out_sel"}, {14'd0, out_sel}, {14'd0, m_sel});
    end
  endtask

  initial begin
    // ptr starts at 0 after reset; comments give ptr after each vector.
    tab1.push_back(mk(4'b0100, 16'h0900, 4'hF, 1'b1, 4'b0100)); // single req 2 -> ptr3
    tab1.push_back(mk(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000)); // drain, ptr3
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b1, 4'b1000)); // 3 -> ptr0
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b1, 4'b0001)); // 0
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b1, 4'b0010)); // 1
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b1, 4'b0100)); // 2
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b1, 4'b1000)); // 3 wrap
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b1, 4'b0001)); // 0 -> ptr1
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b0, 4'b0000)); // stall
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b0, 4'b0000)); // stall
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b0, 4'b0000)); // stall
    tab1.push_back(mk(4'b1111, 16'hdcba, 4'hF, 1'b1, 4'b0010)); // release -> 1, ptr2
    tab1.push_back(mk(4'b1010, 16'h5432, 4'hF, 1'b1, 4'b1000)); // skip 2 -> 3, ptr0
    tab1.push_back(mk(4'b1010, 16'h5432, 4'hF, 1'b1, 4'b0010)); // 1, ptr2
    tab1.push_back(mk(4'b0010, 16'hxx7x, 4'hF, 1'b1, 4'b0010)); // X on others, ptr2
    tab1.push_back(mk(4'b0000, 16'h0000, 4'hF, 1'b0, 4'b0000)); // stall, nothing valid
    tab1.push_back(mk(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000)); // drain, ptr holds 2
    tab1.push_back(mk(4'b1111, 16'h1234, 4'hF, 1'b0, 4'b0100)); // empty slot is free -> 2
    tab1.push_back(mk(4'b1111, 16'h1234, 4'hF, 1'b0, 4'b0000)); // stall
    tab1.push_back(mk(4'b0001, 16'h1234, 4'hF, 1'b1, 4'b0001)); // ptr3 -> 0, ptr1

    // After the mid-stream reset ptr is 0 again.
    tab2.push_back(mk(4'b1010, 16'h5432, 4'hF, 1'b1, 4'b0010)); // first grant 1, ptr2
    tab2.push_back(mk(4'b0001, 16'h0008, 4'hF, 1'b1, 4'b0001)); // 0, ptr1
    tab2.push_back(mk(4'b0110, 16'h0860, 4'b0000, 1'b1, 4'b0010)); // req1 beat 1
`ifdef RR_MUX_ARBITER_4_LOCK_EN
    tab2.push_back(mk(4'b0110, 16'h0860, 4'b0000, 1'b1, 4'b0010)); // locked on 1
`else
    tab2.push_back(mk(4'b0110, 16'h0860, 4'b0000, 1'b1, 4'b0100)); // alternates to 2
`endif
    tab2.push_back(mk(4'b0110, 16'h0860, 4'b0010, 1'b1, 4'b0010)); // req1 last beat
    tab2.push_back(mk(4'b0110, 16'h0860, 4'b0010, 1'b1, 4'b0100)); // then 2
    tab2.push_back(mk(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000)); // drain

    // Power-on reset: all outputs zero and no ready even with requests.
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_data   = 16'hffff;
    in_last   = 4'hF;
    out_ready = 1'b1;
    m_ovalid  = 1'b0;
    m_data    = 4'd0;
    m_sel     = 2'd0;
    #3;
    check("reset in_ready", {12'd0, in_ready}, 16'd0);
    check("reset out_valid", {15'd0, out_valid}, 16'd0);
    check("reset out_data", {12'd0, out_data}, 16'd0);
    check("reset out_sel", {14'd0, out_sel}, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset held in_ready", {12'd0, in_ready}, 16'd0);
    in_valid = 4'h0;
    rst      = 1'b0;

    for (int i = 0; i < tab1.size(); i++) apply(tab1[i], $sformatf("t1[%0d]", i));

    // Mid-stream asynchronous reset while a beat sits in the output slot.
    in_valid  = 4'b1010;
    in_data   = 16'h5432;
    out_ready = 1'b0;
    #2;
    check("pre-reset out_valid", {15'd0, out_valid}, 16'd1);
    rst = 1'b1;
    #1;
    check("mid reset out_valid", {15'd0, out_valid}, 16'd0);
    check("mid reset out_sel", {14'd0, out_sel}, 16'd0);
    check("mid reset out_data", {12'd0, out_data}, 16'd0);
    check("mid reset in_ready", {12'd0, in_ready}, 16'd0);
    sbq.delete();
    m_ovalid = 1'b0;
    m_data   = 4'd0;
    m_sel    = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tab2.size(); i++) apply(tab2[i], $sformatf("t2[%0d]", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
